// File: rtl/pin_pkg.sv
// Shared constants and helpers for the pin input-conditioning stage.
package pin_pkg;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int DEB_CYCLES_SIM  = 4;

  // Counter must hold DEB_CYCLES-1; never narrower than one bit.
  function automatic int deb_cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// Single-bit synchroniser + debounce counter with registered level and edge pulses.
module debounce_bit
  import pin_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int DEB_CYCLES  = DEB_CYCLES_SIM
) (
  input  logic clk,
  input  logic rst,
  input  logic pin_in,
  output logic level,
  output logic rise,
  output logic fall,
  output logic flip_nxt
);

  localparam int             CW     = deb_cnt_w(DEB_CYCLES);
  localparam logic [CW-1:0]  CNT_TC = CW'(DEB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_level;
  logic                   r_rise;
  logic                   r_fall;
  logic                   w_s;

  assign w_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], pin_in};
    end
  end

  // Flip happens on the edge where the mismatch has persisted DEB_CYCLES evaluations.
  assign flip_nxt = (w_s != r_level) && (r_cnt == CNT_TC);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_rise <= flip_nxt & w_s;
      r_fall <= flip_nxt & ~w_s;
      if (w_s == r_level) begin
        r_cnt <= '0;
      end else if (flip_nxt) begin
        r_level <= w_s;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign level = r_level;
  assign rise  = r_rise;
  assign fall  = r_fall;

endmodule

// File: rtl/pin_debounce.sv
// Per-pin synchronise/debounce for one GPIO port, with rise/fall/changed outputs.
// Optional sticky pin-change interrupt compiled in with PIN_IRQ_EN.
module pin_debounce
  import pin_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int DEB_CYCLES  = DEB_CYCLES_SIM
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pin_in,
  output logic [WIDTH-1:0] pin_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed
`ifdef PIN_IRQ_EN
  ,
  input  logic [WIDTH-1:0] irq_mask,
  input  logic [WIDTH-1:0] irq_clr,
  output logic             irq
`endif
);

  logic [WIDTH-1:0] w_level;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_flip;
  logic             r_changed;

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    debounce_bit #(
      .SYNC_STAGES(SYNC_STAGES),
      .DEB_CYCLES (DEB_CYCLES)
    ) u_bit (
      .clk     (clk),
      .rst     (rst),
      .pin_in  (pin_in[g]),
      .level   (w_level[g]),
      .rise    (w_rise[g]),
      .fall    (w_fall[g]),
      .flip_nxt(w_flip[g])
    );
  end

  // Built from next-state flips so it lands in the same cycle as the pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_changed <= 1'b0;
    end else begin
      r_changed <= |w_flip;
    end
  end

  assign pin_out = w_level;
  assign rise    = w_rise;
  assign fall    = w_fall;
  assign changed = r_changed;

`ifdef PIN_IRQ_EN
  logic [WIDTH-1:0] r_pending;
  logic             r_irq;

  // Set wins over clear; masking never drops an already-pending flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pending <= '0;
      r_irq     <= 1'b0;
    end else begin
      r_pending <= (r_pending & ~irq_clr) | ((w_rise | w_fall) & irq_mask);
      r_irq     <= |r_pending;
    end
  end

  assign irq = r_irq;
`endif

endmodule

// File: tb/tb_pin_debounce.sv
// Scoreboard bench for pin_debounce: window-based reference model plus directed latency checks.
module tb_pin_debounce;

  localparam int W    = 8;
  localparam int SYNC = 2;
  localparam int DEB  = 4;

  typedef struct packed {
    logic [W-1:0] out;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic         changed;
    logic         irq;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] pin_in = '0;
  logic [W-1:0] pin_out, rise, fall;
  logic         changed;
`ifdef PIN_IRQ_EN
  logic [W-1:0] irq_mask = '0;
  logic [W-1:0] irq_clr  = '0;
  logic         irq;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  exp_t exp_q[$];

  pin_debounce #(.WIDTH(W), .SYNC_STAGES(SYNC), .DEB_CYCLES(DEB)) dut (
    .clk    (clk),
    .rst    (rst),
    .pin_in (pin_in),
    .pin_out(pin_out),
    .rise   (rise),
    .fall   (fall),
    .changed(changed)
`ifdef PIN_IRQ_EN
    ,
    .irq_mask(irq_mask),
    .irq_clr (irq_clr),
    .irq     (irq)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_assert++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // s(k) is pin_in as sampled SYNC edges earlier; a bit flips at edge k when the
  // last DEB values of s, all taken after its previous flip/reset, differ from pin_out.
  logic [W-1:0] sq[$];
  logic [W-1:0] s_hist[$];
  int           last_evt[W];
  logic [W-1:0] m_out;
  logic [W-1:0] m_pend;
  logic [W-1:0] m_prev_pulse;

  task automatic model_reset();
    sq.delete();
    for (int i = 0; i < SYNC; i++) sq.push_back('0);
    s_hist.delete();
    for (int b = 0; b < W; b++) last_evt[b] = 0;
    m_out        = '0;
    m_pend       = '0;
    m_prev_pulse = '0;
  endtask

  task automatic model_step(output exp_t e);
    logic [W-1:0] s_now, r, f, hv;
    logic         irq_new;
    int           k;
    bit           ok;
    s_now = sq.pop_front();
    sq.push_back(pin_in);
    s_hist.push_back(s_now);
    k = s_hist.size() - 1;
    r = '0;
    f = '0;
    for (int b = 0; b < W; b++) begin
      ok = (k - last_evt[b] + 1) >= DEB;
      for (int j = 0; j < DEB; j++) begin
        if (ok) begin
          hv = s_hist[k-j];
          if (hv[b] == m_out[b]) ok = 0;
        end
      end
      if (ok) begin
        if (m_out[b]) f[b] = 1'b1; else r[b] = 1'b1;
        m_out[b]    = ~m_out[b];
        last_evt[b] = k + 1;
      end
    end
    irq_new = |m_pend;
`ifdef PIN_IRQ_EN
    m_pend = (m_pend & ~irq_clr) | (m_prev_pulse & irq_mask);
`endif
    m_prev_pulse = r | f;
    e = '{out: m_out, rise: r, fall: f, changed: |(r | f), irq: irq_new};
  endtask

  initial begin : model_proc
    exp_t e;
    model_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        model_reset();
        if (clk) exp_q.push_back('0);
      end else begin
        model_step(e);
        exp_q.push_back(e);
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin : monitor_proc
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pin_out", 32'(pin_out), 32'(e.out));
        chk("rise",    32'(rise),    32'(e.rise));
        chk("fall",    32'(fall),    32'(e.fall));
        chk("changed", 32'(changed), 32'(e.changed));
`ifdef PIN_IRQ_EN
        chk("irq",     32'(irq),     32'(e.irq));
`endif
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  // Counts edges until pin_out reaches v; expects SYNC+DEB.
  task automatic measure(input string nm, input logic [W-1:0] v);
    int n;
    bit seen;
    n    = 0;
    seen = 0;
    while (!seen && n < 30) begin
      @(posedge clk);
      n++;
      #1;
      if (pin_out === v) seen = 1;
    end
    chk(nm, 32'(n), 32'(SYNC + DEB));
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1);
  end

  initial begin : stim
    // Reset with all pins high: full latency after release.
    pin_in = 8'hFF;
    repeat (3) tick();
    rst = 1'b1;
    measure("lat_reset_release", 8'hFF);

    pin_in = 8'h00;
    repeat (10) tick();

    pin_in = 8'h05;
    measure("lat_clean_step", 8'h05);
    tick();
    pin_in = 8'h00;
    repeat (10) tick();

    // Bounce on bit0, then hold high.
    pin_in = 8'h01; tick();
    pin_in = 8'h00; tick();
    pin_in = 8'h01; tick();
    pin_in = 8'h00; tick();
    pin_in = 8'h01;
    measure("lat_after_bounce", 8'h01);
    tick();
    pin_in = 8'h00;
    repeat (10) tick();

    // Short glitch on bit3.
    pin_in = 8'h08;
    repeat (3) tick();
    pin_in = 8'h00;
    repeat (10) tick();
    chk("glitch_bit3", 32'(pin_out[3]), 32'd0);

    // Reset mid-count on bit1.
    pin_in = 8'h02;
    repeat (4) tick();
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    measure("lat_after_midreset", 8'h02);
    tick();

    // Randomised pin activity with mixed short and long holds.
    for (int c = 0; c < 700; c++) begin
      for (int b = 0; b < W; b++)
        if ($urandom_range(7) == 0) pin_in[b] = ~pin_in[b];
      if ($urandom_range(40) == 0) begin
        repeat ($urandom_range(12, 6)) tick();
      end
`ifdef PIN_IRQ_EN
      if ($urandom_range(50) == 0) irq_mask = W'($urandom);
      irq_clr = ($urandom_range(5) == 0) ? W'($urandom) : '0;
`endif
      tick();
    end

    repeat (12) tick();
    chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
